// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the fractional baud-rate generator:
//   NB_DIV       divisor width for the default NB_INT/NB_FRAC split
//   DIV_INT_MIN  smallest integer part a divisor may carry once applied
//   ld_state_e   divisor-load handshake states
//   clogb2()     ceil(log2(n)), minimum 1, for counter widths
//   def_div()    reset-time divisor in int.frac fixed point
// -----------------------------------------------------------------------------
package baud_pkg;

  localparam int NB_INT_DEF  = 12;
  localparam int NB_FRAC_DEF = 8;
  localparam int NB_DIV      = NB_INT_DEF + NB_FRAC_DEF;
  localparam int DIV_INT_MIN = 2;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,  // ready for a new divisor
    LD_PEND = 2'd1,  // shadow holds a divisor waiting for a period boundary
    LD_DONE = 2'd2   // divisor just applied, ready returns next cycle
  } ld_state_e;

  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // With the fraction compiled in the ratio is truncated to NB_FRAC bits;
  // without it the ratio is rounded to the nearest integer and the fraction
  // field is left at zero.
  function automatic longint unsigned def_div(input longint unsigned clk_freq,
                                              input longint unsigned baud,
                                              input longint unsigned os,
                                              input longint unsigned nb_frac,
                                              input bit              frac_en);
    longint unsigned den;
    den = baud * os;
    if (frac_en) return (clk_freq << nb_frac) / den;
    else         return ((clk_freq + den / 2) / den) << nb_frac;
  endfunction

endpackage

// File: rtl/frac_tick_div.sv
// -----------------------------------------------------------------------------
// frac_tick_div
// Period counter plus fractional accumulator producing the oversampling tick.
// Period P = i_div_int + carry, where carry is the carry-out of the
// accumulator update made at the previous tick.
// Configuration macro: BAUD_GEN_FRAC_EN (accumulator present when defined;
// otherwise carry is 0 and i_div_frac is unused).
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_enable           run; when low counter/accumulator are held at 0
//   i_sync             restart the period counter (accumulator kept)
//   i_div_int          integer part of the active divisor (already clamped)
//   i_div_frac         fractional part of the active divisor
//   o_tick_due         combinational: o_tick will be set at this edge
//   o_tick             registered one-cycle tick
// -----------------------------------------------------------------------------
module frac_tick_div
  import baud_pkg::*;
#(
  parameter int NB_INT  = 12,
  parameter int NB_FRAC = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_sync,
  input  logic [NB_INT-1:0]  i_div_int,
  input  logic [NB_FRAC-1:0] i_div_frac,
  output logic               o_tick_due,
  output logic               o_tick
);

  logic [NB_INT-1:0] cnt;
  logic              carry;
  logic [NB_INT:0]   p_m1;

  // One extra bit so DIV_INT = 2^NB_INT-1 plus a carry still compares cleanly.
  assign p_m1 = ({1'b0, i_div_int} + (NB_INT+1)'(carry)) - (NB_INT+1)'(1);

  // A sync in the same cycle wins over a tick that is due.
  assign o_tick_due = i_enable && !i_sync && ({1'b0, cnt} == p_m1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (!i_enable || i_sync) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (o_tick_due) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + NB_INT'(1);
      o_tick <= 1'b0;
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [NB_FRAC-1:0] acc;
  logic [NB_FRAC:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, i_div_frac};

  // The carry is registered so it stretches the period that starts after
  // the tick, never the one in progress.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (!i_enable) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (o_tick_due) begin
      acc   <= acc_sum[NB_FRAC-1:0];
      carry <= acc_sum[NB_FRAC];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^i_div_frac;
  assign carry       = 1'b0;
`endif

endmodule

// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
// Programmable fractional baud-rate generator. Emits an oversampling tick
// (o_tick) and a bit tick (o_bit_tick, every OVERSAMPLING-th o_tick) from a
// runtime-loadable int.frac divisor.
// Configuration macro: BAUD_GEN_FRAC_EN -- defined: fractional accumulator
// present; undefined: P = DIV_INT, fraction bits ignored/read as 0, and the
// reset divisor is rounded to an integer.
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_enable           run the generator
//   i_sync             restart period counter and bit phase
//   i_div/i_div_valid  divisor offer; o_div_ready accepts it
//   o_div              divisor currently in use (clamped)
//   o_tick, o_bit_tick registered one-cycle ticks
//
// Divisor handshake: a transfer happens on a rising edge where i_div_valid
// and o_div_ready are both high. o_div_ready is low from the cycle after the
// transfer until the cycle after the new divisor becomes active (at the next
// tick, or on the next cycle while disabled); i_div_valid without ready has
// no effect.
// -----------------------------------------------------------------------------
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 19200,
  parameter int OVERSAMPLING = 16,   // must be >= 2
  parameter int NB_INT       = 12,
  parameter int NB_FRAC      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic                      i_sync,
  input  logic [NB_INT+NB_FRAC-1:0] i_div,
  input  logic                      i_div_valid,
  output logic                      o_div_ready,
  output logic [NB_INT+NB_FRAC-1:0] o_div,
  output logic                      o_tick,
  output logic                      o_bit_tick
);

  localparam int W     = NB_INT + NB_FRAC;
  localparam int NB_PH = clogb2(OVERSAMPLING);

`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif

  localparam logic [W-1:0] DEF_DIV =
    W'(def_div(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLING),
               64'(NB_FRAC), FRAC_EN));

  ld_state_e        ld_state;
  logic [W-1:0]     shadow;
  logic [W-1:0]     active;
  logic [NB_PH-1:0] phase;
  logic             tick_due;

  // Clamp the integer part and, without the fraction hardware, drop the
  // fraction so o_div reflects exactly what the counter uses.
  function automatic logic [W-1:0] apply_div(input logic [W-1:0] d);
    logic [NB_INT-1:0]  di;
    logic [NB_FRAC-1:0] df;
    di = d[W-1:NB_FRAC];
    df = d[NB_FRAC-1:0];
    if (di < NB_INT'(DIV_INT_MIN)) di = NB_INT'(DIV_INT_MIN);
    if (!FRAC_EN) df = '0;
    return {di, df};
  endfunction

  frac_tick_div #(
    .NB_INT  (NB_INT),
    .NB_FRAC (NB_FRAC)
  ) u_tick_div (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_sync     (i_sync),
    .i_div_int  (active[W-1:NB_FRAC]),
    .i_div_frac (active[NB_FRAC-1:0]),
    .o_tick_due (tick_due),
    .o_tick     (o_tick)
  );

  // Load FSM. Swapping the divisor only at the edge that raises o_tick means
  // the period in progress always finishes with the old value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ld_state    <= LD_IDLE;
      o_div_ready <= 1'b1;
      shadow      <= '0;
      active      <= DEF_DIV;
    end else begin
      case (ld_state)
        LD_IDLE: begin
          if (i_div_valid && o_div_ready) begin
            shadow      <= i_div;
            o_div_ready <= 1'b0;
            ld_state    <= LD_PEND;
          end
        end
        LD_PEND: begin
          if (tick_due || !i_enable) begin
            active   <= apply_div(shadow);
            ld_state <= LD_DONE;
          end
        end
        LD_DONE: begin
          o_div_ready <= 1'b1;
          ld_state    <= LD_IDLE;
        end
        default: begin
          o_div_ready <= 1'b1;
          ld_state    <= LD_IDLE;
        end
      endcase
    end
  end

  // Bit phase advances with each tick; the wrapping tick carries o_bit_tick.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase      <= '0;
      o_bit_tick <= 1'b0;
    end else if (!i_enable || i_sync) begin
      phase      <= '0;
      o_bit_tick <= 1'b0;
    end else if (tick_due) begin
      if (phase == NB_PH'(OVERSAMPLING - 1)) begin
        phase      <= '0;
        o_bit_tick <= 1'b1;
      end else begin
        phase      <= phase + NB_PH'(1);
        o_bit_tick <= 1'b0;
      end
    end else begin
      o_bit_tick <= 1'b0;
    end
  end

  assign o_div = active;

endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
// Directed bench for baud_gen_frac with default parameters. Expected values
// are hand-derived for the selected BAUD_GEN_FRAC_EN configuration.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_baud_gen_frac;

  localparam int W = 20;

`ifdef BAUD_GEN_FRAC_EN
  localparam int DEF_DIV     = 41666;  // 162 + 194/256
  localparam int DEF_P_FIRST = 162;    // accumulator starts at 0, no carry
  localparam int NPER        = 256;
  localparam int EXP_LONG    = 194;
  localparam int EXP_SHORT   = 62;
  localparam int EXP_OLD_P   = 162;    // acc back at 0 after 256 updates
  localparam int DIV_10_80   = 2688;
  localparam int EXP_ALT [6] = '{11, 11, 10, 11, 10, 11};
  localparam int EXP_CLAMP [4] = '{3, 2, 2, 2};
`else
  localparam int DEF_DIV     = 41728;  // 163.0
  localparam int DEF_P_FIRST = 163;
  localparam int NPER        = 32;
  localparam int EXP_LONG    = 32;
  localparam int EXP_SHORT   = 0;
  localparam int EXP_OLD_P   = 163;
  localparam int DIV_10_80   = 2560;   // fraction reads back as 0
  localparam int EXP_ALT [6] = '{10, 10, 10, 10, 10, 10};
  localparam int EXP_CLAMP [4] = '{2, 2, 2, 2};
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sync;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic [W-1:0] div_out;
  logic         tick;
  logic         bit_tick;

  int cyc   = 0;
  int stray = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int last_tick = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A bit tick must always coincide with a tick.
  always @(negedge clk) if (bit_tick && !tick) stray <= stray + 1;

  baud_gen_frac dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_sync      (sync),
    .i_div       (div_in),
    .i_div_valid (div_valid),
    .o_div_ready (div_ready),
    .o_div       (div_out),
    .o_tick      (tick),
    .o_bit_tick  (bit_tick)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Waits (bounded) for the next o_tick, sampled on the falling edge.
  // period = cycles since the previous reference point.
  task automatic wait_tick(input int budget, output int period, output logic bt);
    int   n;
    logic timed_out;
    n = 0;
    timed_out = 1'b1;
    while (timed_out && n < budget) begin
      @(negedge clk);
      n++;
      if (tick) timed_out = 1'b0;
    end
    check_eq("tick_timeout", int'(timed_out), 0);
    period    = cyc - last_tick;
    last_tick = cyc;
    bt        = bit_tick;
  endtask

  // Called on the negedge of a tick cycle; offers one divisor for one cycle.
  task automatic load_div(input logic [W-1:0] d);
    check_eq("ready_idle", int'(div_ready), 1);
    div_in    = d;
    div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    check_eq("ready_drop", int'(div_ready), 0);
  endtask

  // ---------------- stimulus ----------------
  int   p;
  logic bt;
  int   n_long, n_short, n_bt, bt_bad, bt_idx, quiet;

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; div_valid = 1'b0; div_in = '0;
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_tick",     int'(tick), 0);
    check_eq("rst_bit_tick", int'(bit_tick), 0);
    check_eq("rst_ready",    int'(div_ready), 1);
    check_eq("rst_div",      int'(div_out), DEF_DIV);

    // default divisor
    en = 1'b1; rst_n = 1'b1; last_tick = cyc;
    wait_tick(400, p, bt);
    check_eq("first_period", p, DEF_P_FIRST);
    n_long = 0; n_short = 0; n_bt = 0; bt_bad = 0;
    for (int i = 2; i <= NPER + 1; i++) begin
      wait_tick(400, p, bt);
      if (p == 163) n_long++;
      else if (p == 162) n_short++;
      if (bt) begin
        n_bt++;
        if (i % 16 != 0) bt_bad++;
      end
    end
    check_eq("long_periods",  n_long, EXP_LONG);
    check_eq("short_periods", n_short, EXP_SHORT);
    check_eq("bit_tick_count", n_bt, NPER / 16);
    check_eq("bit_tick_place", bt_bad, 0);
    check_eq("def_div_kept",   int'(div_out), DEF_DIV);

    // 10.0x80 load: current period completes, new divisor at the tick
    load_div({12'd10, 8'h80});
    check_eq("div_before_apply", int'(div_out), DEF_DIV);
    wait_tick(400, p, bt);
    check_eq("old_period_kept", p, EXP_OLD_P);
    check_eq("div_10_80", int'(div_out), DIV_10_80);
    check_eq("ready_low_at_apply", int'(div_ready), 0);
    @(negedge clk);
    check_eq("ready_back", int'(div_ready), 1);
    for (int i = 0; i < 6; i++) begin
      wait_tick(40, p, bt);
      check_eq("alt_period", p, EXP_ALT[i]);
    end

    // clamp: DIV_INT 0 becomes 2
    load_div({12'd0, 8'h00});
    wait_tick(40, p, bt);
    check_eq("old_period_10", p, 10);
    check_eq("div_clamped", int'(div_out), 512);
    @(negedge clk);
    check_eq("ready_back_clamp", int'(div_ready), 1);
    for (int i = 0; i < 4; i++) begin
      wait_tick(10, p, bt);
      check_eq("clamp_period", p, EXP_CLAMP[i]);
    end

    // 20.0 for the sync test
    load_div({12'd20, 8'h00});
    wait_tick(10, p, bt);
    check_eq("old_period_2", p, 2);
    check_eq("div_20", int'(div_out), 5120);
    @(negedge clk);
    wait_tick(40, p, bt);
    check_eq("period_20", p, 20);

    // sync on the cycle before the next tick is due
    repeat (19) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check_eq("sync_suppress_tick", int'(tick), 0);
    check_eq("sync_suppress_bit",  int'(bit_tick), 0);
    last_tick = cyc;
    bt_idx = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(40, p, bt);
      if (k == 1) check_eq("sync_first_period", p, 20);
      if (bt && bt_idx == 0) bt_idx = k;
    end
    check_eq("sync_bit_phase", bt_idx, 16);

    // disable with a divisor pending: applied on the next cycle
    check_eq("ready_idle_dis", int'(div_ready), 1);
    div_in = {12'd30, 8'h00}; div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; en = 1'b0;
    check_eq("ready_drop_dis", int'(div_ready), 0);
    @(negedge clk);
    check_eq("div_applied_dis", int'(div_out), 7680);
    @(negedge clk);
    check_eq("ready_back_dis", int'(div_ready), 1);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick || bit_tick) quiet++;
    end
    check_eq("quiet_disabled", quiet, 0);
    en = 1'b1; last_tick = cyc;
    wait_tick(100, p, bt);
    check_eq("enable_first_period", p, 30);

    // reset with a divisor pending
    load_div({12'd50, 8'h00});
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ready", int'(div_ready), 1);
    check_eq("arst_div",   int'(div_out), DEF_DIV);
    check_eq("arst_tick",  int'(tick | bit_tick), 0);
    @(negedge clk);
    rst_n = 1'b1; last_tick = cyc;
    wait_tick(400, p, bt);
    check_eq("post_reset_period", p, DEF_P_FIRST);
    check_eq("shadow_discarded", int'(div_out), DEF_DIV);

    check_eq("stray_bit_tick", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
